// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU bus: decodes each request into RAM, MMIO or ROM,
// performs one device access with per-region wait states, then pulses ready with registered data.
module mem_bus_responder #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hF000,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 16'hE000,
  parameter int                    ROM_WAIT   = 1,
  parameter int                    RAM_WAIT   = 0,
  parameter int                    MMIO_WAIT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
  input  logic [DATA_WIDTH-1:0] cpu_mem_data_out,
  output logic [DATA_WIDTH-1:0] cpu_mem_data_in,
  output logic                  cpu_mem_ready,
  output logic                  cpu_bus_error,
  output logic                  bus_busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-5:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic [7:0]            mmio_addr,
  output logic                  mmio_rd,
  output logic                  mmio_wr,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESPOND} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ILLEGAL}            op_e;
  typedef enum logic [1:0] {RG_RAM, RG_MMIO, RG_ROM}                  region_e;

  localparam logic [2:0] ROM_WAIT_C  = 3'(ROM_WAIT);
  localparam logic [2:0] RAM_WAIT_C  = 3'(RAM_WAIT);
  localparam logic [2:0] MMIO_WAIT_C = 3'(MMIO_WAIT);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  region_e               region_q, region_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] mmio_hold_q, mmio_hold_d;

  region_e    req_region;
  logic [2:0] region_wait;
  logic       last_cycle;

  always_comb begin
    if (cpu_mem_address >= ROM_BASE)       req_region = RG_ROM;
    else if (cpu_mem_address >= MMIO_BASE) req_region = RG_MMIO;
    else                                   req_region = RG_RAM;
  end

  always_comb begin
    case (region_q)
      RG_ROM:  region_wait = ROM_WAIT_C;
      RG_MMIO: region_wait = MMIO_WAIT_C;
      default: region_wait = RAM_WAIT_C;
    endcase
  end

  // True on the cycle whose closing edge hands over to RESPOND.
  assign last_cycle = ((state_q == ST_ACCESS) && (region_wait == 3'd0)) ||
                      ((state_q == ST_WAIT)   && (cnt_q == 3'd1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    region_d    = region_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    data_in_d   = data_in_q;
    mmio_hold_d = mmio_hold_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_mem_read || cpu_mem_write) begin
          addr_d   = cpu_mem_address;
          wdata_d  = cpu_mem_data_out;
          region_d = req_region;
          if ((cpu_mem_read && cpu_mem_write) || (cpu_mem_write && req_region == RG_ROM))
            op_d = OP_ILLEGAL;
          else if (cpu_mem_write)
            op_d = OP_WRITE;
          else
            op_d = OP_READ;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = region_wait;
        if (op_q == OP_READ && region_q == RG_MMIO) mmio_hold_d = mmio_rdata;
        state_d = (region_wait == 3'd0) ? ST_RESPOND : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_RESPOND;
      end
      default: state_d = ST_IDLE;
    endcase

    // MMIO data is only valid during the strobe, so a waited MMIO read uses the held copy.
    if (last_cycle && op_q == OP_READ) begin
      case (region_q)
        RG_ROM:  data_in_d = rom_rdata;
        RG_MMIO: data_in_d = (state_q == ST_ACCESS) ? mmio_rdata : mmio_hold_q;
        default: data_in_d = ram_rdata;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      region_q    <= RG_RAM;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      data_in_q   <= '0;
      mmio_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      region_q    <= region_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      data_in_q   <= data_in_d;
      mmio_hold_q <= mmio_hold_d;
    end
  end

  // Strobes decode from the state register, so an async reset drops them at once.
  assign ram_we          = (state_q == ST_ACCESS) && (op_q == OP_WRITE) && (region_q == RG_RAM);
  assign mmio_rd         = (state_q == ST_ACCESS) && (op_q == OP_READ)  && (region_q == RG_MMIO);
  assign mmio_wr         = (state_q == ST_ACCESS) && (op_q == OP_WRITE) && (region_q == RG_MMIO);
  assign cpu_mem_ready   = (state_q == ST_RESPOND);
  assign cpu_bus_error   = (state_q == ST_RESPOND) && (op_q == OP_ILLEGAL);
  assign bus_busy        = (state_q != ST_IDLE);
  assign cpu_mem_data_in = data_in_q;
  assign ram_addr        = addr_q;
  assign ram_wdata       = wdata_q;
  assign rom_addr        = addr_q[ADDR_WIDTH-5:0] - ROM_BASE[ADDR_WIDTH-5:0];
  assign mmio_addr       = addr_q[7:0];
  assign mmio_wdata      = wdata_q;

endmodule
